// File: rtl/mem_bus_arbiter.sv
// Purpose: arbitrates one single-port memory between the CPU port and the loader port (round-robin plus burst limit).
// Latency: gnt one cycle after req from idle; memory strobes are combinational in the granted cycle; rvalid one cycle after a read beat.
// Backpressure: a requester holds req/we/addr/wdata until its gnt and req coincide (a beat); no other stall path exists.
//
// Ports:
//   nclk, rst                                  clock (rising edge), synchronous active-low reset
//   cpu_req/we/addr/wdata -> cpu_gnt/rdata/rvalid  CPU request and read return
//   ld_req/we/addr/wdata  -> ld_gnt/rdata/rvalid   loader request and read return
//   mem_en/we/addr/wdata  -> mem_rdata             memory side; rdata valid one cycle after a read strobe
module mem_bus_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          nclk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic [DW-1:0] ld_rdata,
    output logic          ld_rvalid,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CPU  = 2'd1,
        S_LD   = 2'd2
    } state_t;

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] beat_cnt;
    logic       last_owner;   // 1 = loader owned last, 0 = CPU owned last
    logic       cpu_beat;
    logic       ld_beat;
    logic       burst_done;

    assign cpu_beat = (state == S_CPU) && cpu_req;
    assign ld_beat  = (state == S_LD)  && ld_req;

    // The beat happening this cycle is the one that reaches the limit; a
    // counter already saturated also qualifies, so a late competitor wins
    // on the owner's very next beat.
    assign burst_done = (beat_cnt >= (BURST_LIM - 4'd1));

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (cpu_req && ld_req) begin
                    state_nxt = last_owner ? S_CPU : S_LD;
                end else if (cpu_req) begin
                    state_nxt = S_CPU;
                end else if (ld_req) begin
                    state_nxt = S_LD;
                end
            end
            S_CPU: begin
                if (!cpu_req) begin
                    state_nxt = ld_req ? S_LD : S_IDLE;
                end else if (ld_req && burst_done) begin
                    state_nxt = S_LD;
                end
            end
            S_LD: begin
                if (!ld_req) begin
                    state_nxt = cpu_req ? S_CPU : S_IDLE;
                end else if (cpu_req && burst_done) begin
                    state_nxt = S_CPU;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Memory steering: only a beat drives the bus, everything else parks at 0.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_beat) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (ld_beat) begin
            mem_en    = 1'b1;
            mem_we    = ld_we;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end
    end

    always_ff @(posedge nclk) begin
        if (!rst) begin
            state      <= S_IDLE;
            cpu_gnt    <= 1'b0;
            ld_gnt     <= 1'b0;
            beat_cnt   <= 4'd0;
            last_owner <= 1'b1;
            cpu_rvalid <= 1'b0;
            ld_rvalid  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cpu_gnt <= (state_nxt == S_CPU);
            ld_gnt  <= (state_nxt == S_LD);

            if (state_nxt != state) begin
                beat_cnt <= 4'd0;
            end else if ((cpu_beat || ld_beat) && (beat_cnt < BURST_LIM)) begin
                beat_cnt <= beat_cnt + 4'd1;
            end

            if ((state != S_IDLE) && (state_nxt != state)) begin
                last_owner <= (state == S_LD);
            end

            // Read tag: the rvalid flop of the issuing port carries the tag.
            cpu_rvalid <= cpu_beat && !cpu_we;
            ld_rvalid  <= ld_beat && !ld_we;
        end
    end

    // Shared return path; rvalid tells each consumer whether the data is theirs.
    assign cpu_rdata = mem_rdata;
    assign ld_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          nclk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          ld_req, ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_gnt, ld_rvalid;
    logic [DW-1:0] ld_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 nclk = ~nclk;

    mem_bus_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
        .nclk(nclk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rdata(ld_rdata), .ld_rvalid(ld_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Memory attached to the DUT: one-cycle read latency.
    logic [DW-1:0] tb_mem [256];
    always @(posedge nclk) begin
        if (mem_en) begin
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr];
        end
    end

    // Reference model: owner 0 = nobody, 1 = CPU, 2 = loader.
    logic [DW-1:0] ref_mem [256];
    int   m_own, m_cnt, m_last;
    bit   m_crv, m_lrv, m_cbeat, m_lbeat;
    logic [DW-1:0] m_crd, m_lrd;

    int total = 0;
    int bad   = 0;
    bit d_cbeat, d_lbeat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int beat_owner();
        if (m_own == 1 && cpu_req) return 1;
        if (m_own == 2 && ld_req)  return 2;
        return 0;
    endfunction

    task automatic check_outputs();
        int b;
        b = beat_owner();
        chk("cpu_gnt", cpu_gnt, m_own == 1);
        chk("ld_gnt", ld_gnt, m_own == 2);
        chk("mem_en", mem_en, b != 0);
        chk("mem_we", mem_we, (b == 1) ? cpu_we : (b == 2) ? ld_we : 1'b0);
        chk("mem_addr", mem_addr, (b == 1) ? cpu_addr : (b == 2) ? ld_addr : 8'h00);
        chk("mem_wdata", mem_wdata, (b == 1) ? cpu_wdata : (b == 2) ? ld_wdata : 8'h00);
        chk("cpu_rvalid", cpu_rvalid, m_crv);
        chk("ld_rvalid", ld_rvalid, m_lrv);
        if (m_crv) chk("cpu_rdata", cpu_rdata, m_crd);
        if (m_lrv) chk("ld_rdata", ld_rdata, m_lrd);
    endtask

    task automatic update_model();
        int  b, nxt, oth;
        bit  own_req, oth_req;
        b = beat_owner();
        m_cbeat = (b == 1);
        m_lbeat = (b == 2);
        m_crv = 0;
        m_lrv = 0;
        if (b == 1) begin
            if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
            else begin m_crv = 1; m_crd = ref_mem[cpu_addr]; end
        end else if (b == 2) begin
            if (ld_we) ref_mem[ld_addr] = ld_wdata;
            else begin m_lrv = 1; m_lrd = ref_mem[ld_addr]; end
        end
        if (!rst) begin
            m_own = 0; m_cnt = 0; m_last = 2; m_crv = 0; m_lrv = 0;
            return;
        end
        own_req = (m_own == 1) ? cpu_req : ld_req;
        oth_req = (m_own == 1) ? ld_req : cpu_req;
        oth     = 3 - m_own;
        if (m_own == 0) begin
            if (cpu_req && ld_req) nxt = 3 - m_last;
            else if (cpu_req)      nxt = 1;
            else if (ld_req)       nxt = 2;
            else                   nxt = 0;
        end else if (!own_req) begin
            nxt = oth_req ? oth : 0;
        end else if (oth_req && (m_cnt + 1 >= MB)) begin
            nxt = oth;
        end else begin
            nxt = m_own;
        end
        if (nxt != m_own) begin
            if (m_own != 0) m_last = m_own;
            m_cnt = 0;
        end else if (b != 0) begin
            m_cnt = (m_cnt + 1 > MB) ? MB : m_cnt + 1;
        end
        m_own = nxt;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic tick();
        @(negedge nclk);
        check_outputs();
        d_cbeat = cpu_gnt && mem_en;
        d_lbeat = ld_gnt && mem_en;
        @(posedge nclk);
        update_model();
        #1;
    endtask

    initial begin
        int cgap, lgap, maxgap;
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = 8'($urandom);
            ref_mem[i] = tb_mem[i];
        end
        tb_mem[8'h10]  = 8'hA5;
        ref_mem[8'h10] = 8'hA5;
        m_own = 0; m_cnt = 0; m_last = 2; m_crv = 0; m_lrv = 0;
        m_cbeat = 0; m_lbeat = 0; m_crd = '0; m_lrd = '0;

        // Reset with both requesting.
        rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 8'h01; ld_wdata  = 8'h00;
        @(posedge nclk); #1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rst_rel_cpu_gnt", cpu_gnt, 1'b1);
        chk("rst_rel_ld_gnt", ld_gnt, 1'b0);
        tick();
        cpu_req = 1'b0; ld_req = 1'b0;
        tick(); tick();

        // CPU reads 0x10.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        tick();
        chk("cpu_rd_mem_en", mem_en, 1'b1);
        chk("cpu_rd_mem_we", mem_we, 1'b0);
        chk("cpu_rd_mem_addr", mem_addr, 8'h10);
        tick();
        cpu_req = 1'b0;
        chk("cpu_rd_rvalid", cpu_rvalid, 1'b1);
        chk("cpu_rd_rdata", cpu_rdata, 8'hA5);
        chk("cpu_rd_ld_rvalid", ld_rvalid, 1'b0);
        tick();

        // Loader writes 0x3C to 0x20, then reads it back.
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h20; ld_wdata = 8'h3C;
        tick();
        chk("ld_wr_mem_we", mem_we, 1'b1);
        chk("ld_wr_mem_wdata", mem_wdata, 8'h3C);
        tick();
        ld_we = 1'b0;
        chk("ld_wr_no_rvalid", ld_rvalid, 1'b0);
        tick();
        ld_req = 1'b0;
        chk("ld_rd_rvalid", ld_rvalid, 1'b1);
        chk("ld_rd_rdata", ld_rdata, 8'h3C);
        tick(); tick();

        // Both hold requests: fairness and bounded waiting.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h30;
        ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 8'h31;
        cgap = 0; lgap = 0; maxgap = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            cgap = d_cbeat ? 0 : cgap + 1;
            lgap = d_lbeat ? 0 : lgap + 1;
            if (cgap > maxgap) maxgap = cgap;
            if (lgap > maxgap) maxgap = lgap;
        end
        chk("burst_max_idle_le5", maxgap <= 5, 1'b1);
        cpu_req = 1'b0; ld_req = 1'b0;
        tick(); tick();

        // CPU releases after two beats while the loader waits.
        cpu_req = 1'b1; cpu_addr = 8'h40;
        tick();
        ld_req = 1'b1; ld_addr = 8'h41;
        tick(); tick();
        cpu_req = 1'b0;
        tick();
        chk("release_ld_gnt", ld_gnt, 1'b1);
        chk("release_cpu_gnt", cpu_gnt, 1'b0);
        cpu_req = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        cpu_req = 1'b0; ld_req = 1'b0;
        tick(); tick();

        // Reset landing on a CPU read beat.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
        tick();
        rst = 1'b0;
        tick();
        chk("rst_beat_rvalid", cpu_rvalid, 1'b0);
        chk("rst_beat_gnt", cpu_gnt, 1'b0);
        rst = 1'b1; cpu_req = 1'b0;
        tick();

        // Random traffic obeying the hold-until-beat rule.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) != 0);
            if (cpu_req && !m_cbeat) begin
                if ($urandom_range(0, 15) == 0) cpu_req = 1'b0;
            end else begin
                cpu_req   = ($urandom_range(0, 99) < 55);
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = 8'($urandom_range(0, 15));
                cpu_wdata = 8'($urandom);
            end
            if (ld_req && !m_lbeat) begin
                if ($urandom_range(0, 15) == 0) ld_req = 1'b0;
            end else begin
                ld_req   = ($urandom_range(0, 99) < 55);
                ld_we    = 1'($urandom_range(0, 1));
                ld_addr  = 8'($urandom_range(0, 15));
                ld_wdata = 8'($urandom);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
